serial_alu_xn: RTL and testbench
================================

Name: serial_alu_xn

Overview:
- Parametrised bit-serial successor to the team's registered 1-bit sum/pass cell.
- Latches two WIDTH-bit operands on a start pulse and processes them LSB-first, one bit per clock.
- Supports four modes: ADD, SUB, XOR (sum, carry ignored) and PASS_B.
- Presents a registered WIDTH-bit result with a done pulse. Used as a low-area datapath element in the lab designs.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  request to begin an operation; sampled only when not busy.
- mode_i  input  2  operation: 00 ADD, 01 XOR, 10 PASS_B, 11 SUB; sampled with start_i.
- B_i  input  WIDTH  operand B; sampled with start_i.
- D_i  input  WIDTH  operand D; sampled with start_i.
- busy_o  output  1  high while an operation is in progress (RUN state).
- done_o  output  1  one-cycle pulse: E_o and carry_o are valid.
- E_o  output  WIDTH  result register; holds its value until the next accepted start.
- carry_o  output  1  final carry (ADD), not-borrow (SUB), 0 for XOR/PASS_B.
- bit_o  output  1  result bit computed this cycle while busy_o=1, else 0.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; busy_o=0, done_o=0, E_o=0, carry_o=0, bit_o=0.
  - Shift registers, carry register and counter are cleared.
  - Any operation in flight is abandoned, with no done_o.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 at edge k → load B_sh=B_i, D_sh=D_i (D_sh=~D_i for SUB), mode_r=mode_i.
  - Load c = 1 for SUB, else 0; cnt=0; result shift register cleared; go to RUN.
  - E_o keeps its old value until DONE.
- RUN, one bit per edge (edges k+1 .. k+WIDTH):
  - b=B_sh[0], d=D_sh[0].
  - ADD/SUB: s = b^d^c; c <= (b&d)|(c&(b^d)).
  - XOR: s = b^d; c unchanged (0).
  - PASS_B: s = b; c unchanged (0).
  - s shifts into the MSB of the result register; B_sh and D_sh shift right; cnt increments.
  - At edge k+WIDTH (cnt==WIDTH-1 before the edge) → DONE. E_o <= completed result; carry_o <= c (forced 0 for XOR/PASS_B).
- DONE: done_o=1 for exactly one cycle; busy_o=0.
  - start_i=1 in DONE is accepted exactly as in IDLE (back-to-back; new RUN begins next edge).
  - Otherwise go to IDLE.
- Latency: start sampled at edge k → done_o high in the cycle following edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- start_i during RUN is ignored; operands and mode are not re-sampled.
- busy_o and done_o are never high together.
- bit_o is the combinational s during RUN, 0 otherwise.
- Arithmetic is modulo 2^WIDTH. SUB computes B−D; carry_o=1 means B≥D (unsigned).
- Illegal mode values: none exist (2-bit code fully decoded).

Decomposition:
- Package serial_alu_pkg:
  - mode_t enum {MODE_ADD=2'b00, MODE_XOR=2'b01, MODE_PASS_B=2'b10, MODE_SUB=2'b11}.
  - state_t enum {S_IDLE, S_RUN, S_DONE}.
- One sub-module, serial_alu_bit: combinational 1-bit slice with inputs b, d, c, mode and outputs s, c_next. This is the generalised single-bit cell. The top level holds the FSM, counter, shift registers and output registers.

Test Plan (WIDTH=8):
- ADD B=8'h5A, D=8'h3C, start at edge k → busy_o high for 8 cycles; done_o only in the cycle after edge k+8; E_o=8'h96, carry_o=0.
- ADD B=8'hFF, D=8'h01 → E_o=8'h00, carry_o=1. SUB B=8'h10, D=8'h01 → E_o=8'h0F, carry_o=1. SUB B=8'h01, D=8'h02 → E_o=8'hFF, carry_o=0.
- XOR B=8'hA5, D=8'hFF → E_o=8'h5A, carry_o=0. PASS_B B=8'hC3, D=8'h3C → E_o=8'hC3, carry_o=0. bit_o sequence for PASS_B = 1,1,0,0,0,0,1,1.
- Hold start_i=1 with changed operands throughout RUN → result reflects only the first sampled operands. start_i=1 in the DONE cycle → second operation starts with no idle gap; its done_o follows 9 cycles after the first.
- Assert reset mid-RUN (after 4 bits of ADD 8'h5A+8'h3C) → all outputs 0 immediately (asynchronous), no done_o. After release, a fresh ADD 8'h01+8'h01 yields E_o=8'h02.
- E_o hold: after done_o, leave start_i low for 20 cycles → E_o and carry_o stable, done_o stays 0.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared mode and state encodings for the bit-serial ALU.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    MODE_ADD    = 2'b00,
    MODE_XOR    = 2'b01,
    MODE_PASS_B = 2'b10,
    MODE_SUB    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_alu_bit.sv
// One-bit sum/carry slice for the serial ALU; purely combinational, no flow control.
module serial_alu_bit
  import serial_alu_pkg::*;
(
  input  logic       b,
  input  logic       d,
  input  logic       c,
  input  logic [1:0] mode,
  output logic       s,
  output logic       c_next
);

  // SUB reuses the adder: the top inverts D and seeds carry with 1.
  always_comb begin
    s      = 1'b0;
    c_next = c;
    case (mode_t'(mode))
      MODE_ADD, MODE_SUB: begin
        s      = b ^ d ^ c;
        c_next = (b & d) | (c & (b ^ d));
      end
      MODE_XOR:    s = b ^ d;
      MODE_PASS_B: s = b;
      default: begin
        s      = 1'b0;
        c_next = c;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_xn.sv
// Bit-serial ADD/SUB/XOR/PASS_B, LSB first; done_o one cycle after edge start+WIDTH.
// start_i is ignored while busy; a start in the DONE cycle chains with no gap.
module serial_alu_xn
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic [WIDTH-1:0] D_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] E_o,
  output logic             carry_o,
  output logic             bit_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [1:0]         mode_q;
  logic [WIDTH-1:0]   b_sh, d_sh, res_sh, res_nxt;
  logic               c_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               s, c_next, last, load, arith;

  serial_alu_bit u_bit (
    .b      (b_sh[0]),
    .d      (d_sh[0]),
    .c      (c_q),
    .mode   (mode_q),
    .s      (s),
    .c_next (c_next)
  );

  assign last    = (cnt_q == CNT_W'(WIDTH - 1));
  assign load    = start_i && (state_q != S_RUN);
  assign arith   = (mode_q == MODE_ADD) || (mode_q == MODE_SUB);
  assign res_nxt = {s, res_sh[WIDTH-1:1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_RUN;
      S_RUN: begin
        busy_o = 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = start_i ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bit_o = busy_o ? s : 1'b0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b_sh    <= '0;
      d_sh    <= '0;
      res_sh  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_ADD;
      E_o     <= '0;
      carry_o <= 1'b0;
    end else if (load) begin
      b_sh   <= B_i;
      d_sh   <= (mode_t'(mode_i) == MODE_SUB) ? ~D_i : D_i;
      mode_q <= mode_i;
      c_q    <= (mode_t'(mode_i) == MODE_SUB);
      cnt_q  <= '0;
      res_sh <= '0;
    end else if (state_q == S_RUN) begin
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      d_sh   <= {1'b0, d_sh[WIDTH-1:1]};
      res_sh <= res_nxt;
      c_q    <= c_next;
      cnt_q  <= cnt_q + 1'b1;
      if (last) begin
        E_o     <= res_nxt;
        carry_o <= arith ? c_next : 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_xn.sv
// Directed plus random checks of serial_alu_xn (WIDTH=8) against an arithmetic reference model.
module tb_serial_alu_xn;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_i = 1'b0;
  logic [1:0] mode_i = 2'b00;
  logic [7:0] B_i = 8'h00;
  logic [7:0] D_i = 8'h00;
  logic       busy_o, done_o, carry_o, bit_o;
  logic [7:0] E_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cyc = 0;
  int prev_done_cyc = 0;

  serial_alu_xn #(.WIDTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .start_i (start_i),
    .mode_i  (mode_i),
    .B_i     (B_i),
    .D_i     (D_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .E_o     (E_o),
    .carry_o (carry_o),
    .bit_o   (bit_o)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: modulo-256 arithmetic; SUB carry means B >= D unsigned.
  function automatic void model(input logic [7:0] b, input logic [7:0] d, input logic [1:0] m,
                                output logic [7:0] e, output logic c);
    logic [8:0] sum;
    case (m)
      2'b00: begin sum = {1'b0, b} + {1'b0, d}; e = sum[7:0]; c = sum[8]; end
      2'b01: begin e = b ^ d; c = 1'b0; end
      2'b10: begin e = b; c = 1'b0; end
      default: begin e = b - d; c = (b >= d); end
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called #1 after an edge with the DUT in IDLE or DONE; returns in the DONE cycle.
  task automatic run_op(input logic [7:0] b, input logic [7:0] d, input logic [1:0] m,
                        input bit hold);
    logic [7:0] exp_e;
    logic       exp_c;
    model(b, d, m, exp_e, exp_c);
    start_i = 1'b1;
    B_i = b;
    D_i = d;
    mode_i = m;
    step();
    for (int i = 0; i < 8; i++) begin
      if (hold && i < 7) begin
        start_i = 1'b1;
        B_i = 8'($urandom);
        D_i = 8'($urandom);
        mode_i = 2'($urandom);
      end else begin
        start_i = 1'b0;
      end
      chk("busy_run", busy_o, 1);
      chk("done_run", done_o, 0);
      chk("bit_o", bit_o, exp_e[i]);
      step();
    end
    chk("busy_done", busy_o, 0);
    chk("done_pulse", done_o, 1);
    chk("E_o", E_o, exp_e);
    chk("carry_o", carry_o, exp_c);
    prev_done_cyc = done_cyc;
    done_cyc = cyc;
  endtask

  initial begin
    logic [7:0] held_e;
    logic       held_c;

    #12;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_E", E_o, 0);
    chk("rst_carry", carry_o, 0);
    chk("rst_bit", bit_o, 0);
    step();
    reset = 1'b0;
    step();

    run_op(8'h5A, 8'h3C, 2'b00, 0);
    step();
    chk("idle_done", done_o, 0);
    run_op(8'hFF, 8'h01, 2'b00, 0);
    step();
    run_op(8'h10, 8'h01, 2'b11, 0);
    step();
    run_op(8'h01, 8'h02, 2'b11, 0);
    step();
    run_op(8'hA5, 8'hFF, 2'b01, 0);
    step();
    run_op(8'hC3, 8'h3C, 2'b10, 0);
    step();

    // Start held through RUN with changing operands.
    run_op(8'h21, 8'h12, 2'b00, 1);
    step();

    // Back-to-back: second start issued in the DONE cycle.
    run_op(8'h33, 8'h44, 2'b11, 0);
    run_op(8'h44, 8'h33, 2'b11, 0);
    chk("b2b_gap", done_cyc - prev_done_cyc, 9);
    step();

    // Asynchronous reset after four bits of an ADD.
    start_i = 1'b1;
    B_i = 8'h5A;
    D_i = 8'h3C;
    mode_i = 2'b00;
    step();
    start_i = 1'b0;
    repeat (4) step();
    chk("mid_busy", busy_o, 1);
    reset = 1'b1;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_E", E_o, 0);
    chk("arst_carry", carry_o, 0);
    chk("arst_bit", bit_o, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("post_rst_done", done_o, 0);
      step();
    end
    run_op(8'h01, 8'h01, 2'b00, 0);
    held_e = E_o;
    held_c = carry_o;

    // Result hold with start low.
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_E", E_o, held_e);
      chk("hold_carry", carry_o, held_c);
      chk("hold_done", done_o, 0);
    end

    for (int n = 0; n < 40; n++) begin
      run_op(8'($urandom), 8'($urandom), 2'($urandom), 0);
      if (($urandom % 2) == 0) step();
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
